// File: rtl/mirfak_wb_arbiter_pkg.sv
// Shared Mirfak definitions: exception codes plus the memory-port arbiter's
// state and grant encodings.
package mirfak_wb_arbiter_pkg;

  localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;
  localparam logic [3:0] EXC_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] EXC_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_BUSY_I = 3'b010,
    ST_BUSY_D = 3'b100
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // A disabled timer (0 cycles) still needs a legal 1-bit register.
  function automatic int timer_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/mirfak_rr_arbiter2.sv
// Combinational two-way pick between the instruction and data requesters,
// either fixed data-priority or alternating against the last grant.
import mirfak_wb_arbiter_pkg::*;

module mirfak_rr_arbiter2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic   req_ins,
  input  logic   req_dat,
  input  grant_e last_grant,
  output logic   valid,
  output grant_e grant
);

  always_comb begin
    valid = req_ins | req_dat;
    grant = GNT_I;
    if (req_ins && req_dat) begin
      if (!ROUND_ROBIN) grant = GNT_D;
      else              grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (req_dat) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mirfak_wb_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter for the Mirfak unified
// memory port: registered grants, optional round-robin and bus timeout.
import mirfak_wb_arbiter_pkg::*;

module mirfak_wb_arbiter #(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] iwbs_dat_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  iwbs_sel_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        iwbs_cyc_i,
  input  logic        dwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic        dwbs_stb_i,
  input  logic        iwbs_we_i,
  input  logic        dwbs_we_i,
  output logic [31:0] iwbs_dat_o,
  output logic [31:0] dwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        dwbs_ack_o,
  output logic        iwbs_err_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int              TW       = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TMR_MAX  = '1;

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic [TW-1:0] timer_q;
  logic          pick_valid;
  grant_e        pick;
  logic          slave_done;
  logic          timeout;

  assign slave_done = wbm_ack_i | wbm_err_i;
  assign timeout    = (TIMEOUT_CYCLES > 0) && (state_q != ST_IDLE) &&
                      !slave_done && (timer_q == TMR_LAST);

  mirfak_rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN != 0)
  ) u_pick (
    .req_ins    (iwbs_cyc_i & iwbs_stb_i),
    .req_dat    (dwbs_cyc_i & dwbs_stb_i),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Counts granted cycles without a slave response; saturates rather than wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                  timer_q <= '0;
    else if (state_q == ST_IDLE)                timer_q <= '0;
    else if (!slave_done && timer_q != TMR_MAX) timer_q <= timer_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wbm_addr_o   = '0;
    wbm_dat_o    = '0;
    wbm_sel_o    = '0;
    wbm_cyc_o    = 1'b0;
    wbm_stb_o    = 1'b0;
    wbm_we_o     = 1'b0;
    iwbs_dat_o   = '0;
    iwbs_ack_o   = 1'b0;
    iwbs_err_o   = 1'b0;
    dwbs_dat_o   = '0;
    dwbs_ack_o   = 1'b0;
    dwbs_err_o   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = (pick == GNT_D) ? ST_BUSY_D : ST_BUSY_I;
      end
      ST_BUSY_I: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_dat_o  = iwbs_dat_i;
        wbm_sel_o  = iwbs_sel_i;
        wbm_cyc_o  = iwbs_cyc_i;
        wbm_stb_o  = iwbs_stb_i;
        wbm_we_o   = iwbs_we_i;
        iwbs_dat_o = wbm_dat_i;
        iwbs_ack_o = wbm_ack_i;
        iwbs_err_o = wbm_err_i | timeout;
        if (slave_done || timeout) begin
          state_d      = ST_IDLE;
          last_grant_d = GNT_I;
        end else if (!iwbs_cyc_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_D: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_cyc_o  = dwbs_cyc_i;
        wbm_stb_o  = dwbs_stb_i;
        wbm_we_o   = dwbs_we_i;
        dwbs_dat_o = wbm_dat_i;
        dwbs_ack_o = wbm_ack_i;
        dwbs_err_o = wbm_err_i | timeout;
        if (slave_done || timeout) begin
          state_d      = ST_IDLE;
          last_grant_d = GNT_D;
        end else if (!dwbs_cyc_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mirfak_wb_arbiter.sv
// Directed bench for mirfak_wb_arbiter: two instances (round-robin with a
// 4-cycle timeout, fixed-priority with no timeout) share one stimulus stream.
module tb_mirfak_wb_arbiter;

  localparam logic [31:0] I_ADDR = 32'h8000_0000;
  localparam logic [31:0] I_WDAT = 32'h1111_2222;
  localparam logic [3:0]  I_SEL  = 4'hF;
  localparam logic        I_WE   = 1'b0;
  localparam logic [31:0] D_ADDR = 32'h1000_0000;
  localparam logic [31:0] D_WDAT = 32'hCAFE_F00D;
  localparam logic [3:0]  D_SEL  = 4'h3;
  localparam logic        D_WE   = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iwbs_addr = I_ADDR, dwbs_addr = D_ADDR;
  logic [31:0] iwbs_wdat = I_WDAT, dwbs_wdat = D_WDAT;
  logic [3:0]  iwbs_sel = I_SEL, dwbs_sel = D_SEL;
  logic        iwbs_we = I_WE, dwbs_we = D_WE;
  logic        iwbs_cyc = 1'b0, iwbs_stb = 1'b0, dwbs_cyc = 1'b0, dwbs_stb = 1'b0;
  logic [31:0] s_dat = '0;
  logic        s_ack = 1'b0, s_err = 1'b0;

  logic [31:0] a_idat, a_ddat, a_addr, a_wdat, b_idat, b_ddat, b_addr, b_wdat;
  logic        a_iack, a_dack, a_ierr, a_derr, a_cyc, a_stb, a_we;
  logic        b_iack, b_dack, b_ierr, b_derr, b_cyc, b_stb, b_we;
  logic [3:0]  a_sel, b_sel;
  logic [138:0] a_vec, b_vec;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Transaction-level model: owner 0 = bus free, 1 = I master, 2 = D master.
  int own  [2];
  int last [2];
  int cnt  [2];
  int rr_cfg [2] = '{1, 0};
  int to_cfg [2] = '{4, 0};

  always #5 clk = ~clk;

  mirfak_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .iwbs_addr_i(iwbs_addr), .dwbs_addr_i(dwbs_addr),
    .iwbs_dat_i(iwbs_wdat), .dwbs_dat_i(dwbs_wdat),
    .iwbs_sel_i(iwbs_sel), .dwbs_sel_i(dwbs_sel),
    .iwbs_cyc_i(iwbs_cyc), .dwbs_cyc_i(dwbs_cyc),
    .iwbs_stb_i(iwbs_stb), .dwbs_stb_i(dwbs_stb),
    .iwbs_we_i(iwbs_we), .dwbs_we_i(dwbs_we),
    .iwbs_dat_o(a_idat), .dwbs_dat_o(a_ddat),
    .iwbs_ack_o(a_iack), .dwbs_ack_o(a_dack),
    .iwbs_err_o(a_ierr), .dwbs_err_o(a_derr),
    .wbm_addr_o(a_addr), .wbm_dat_o(a_wdat), .wbm_sel_o(a_sel),
    .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_we_o(a_we),
    .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err)
  );

  mirfak_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .iwbs_addr_i(iwbs_addr), .dwbs_addr_i(dwbs_addr),
    .iwbs_dat_i(iwbs_wdat), .dwbs_dat_i(dwbs_wdat),
    .iwbs_sel_i(iwbs_sel), .dwbs_sel_i(dwbs_sel),
    .iwbs_cyc_i(iwbs_cyc), .dwbs_cyc_i(dwbs_cyc),
    .iwbs_stb_i(iwbs_stb), .dwbs_stb_i(dwbs_stb),
    .iwbs_we_i(iwbs_we), .dwbs_we_i(dwbs_we),
    .iwbs_dat_o(b_idat), .dwbs_dat_o(b_ddat),
    .iwbs_ack_o(b_iack), .dwbs_ack_o(b_dack),
    .iwbs_err_o(b_ierr), .dwbs_err_o(b_derr),
    .wbm_addr_o(b_addr), .wbm_dat_o(b_wdat), .wbm_sel_o(b_sel),
    .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_we_o(b_we),
    .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err)
  );

  assign a_vec = {a_addr, a_wdat, a_sel, a_cyc, a_stb, a_we,
                  a_idat, a_iack, a_ierr, a_ddat, a_dack, a_derr};
  assign b_vec = {b_addr, b_wdat, b_sel, b_cyc, b_stb, b_we,
                  b_idat, b_iack, b_ierr, b_ddat, b_dack, b_derr};

  task automatic check(input string name, input logic [138:0] act, input logic [138:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (cycle %0d): got %h required %h", name, cycle, act, exp);
    end
  endtask

  function automatic logic model_tmo(input int k);
    return (to_cfg[k] > 0) && (own[k] != 0) && !s_ack && !s_err && (cnt[k] == to_cfg[k] - 1);
  endfunction

  function automatic logic [138:0] model_out(input int k);
    logic [31:0] addr, wdat, idat, ddat;
    logic [3:0]  sel;
    logic        cyc, stb, we, iack, ierr, dack, derr;
    addr = '0; wdat = '0; idat = '0; ddat = '0; sel = '0;
    cyc = 0; stb = 0; we = 0; iack = 0; ierr = 0; dack = 0; derr = 0;
    if (!rst && own[k] == 1) begin
      addr = I_ADDR; wdat = I_WDAT; sel = I_SEL; we = I_WE;
      cyc = iwbs_cyc; stb = iwbs_stb;
      idat = s_dat; iack = s_ack; ierr = s_err | model_tmo(k);
    end else if (!rst && own[k] == 2) begin
      addr = D_ADDR; wdat = D_WDAT; sel = D_SEL; we = D_WE;
      cyc = dwbs_cyc; stb = dwbs_stb;
      ddat = s_dat; dack = s_ack; derr = s_err | model_tmo(k);
    end
    return {addr, wdat, sel, cyc, stb, we, idat, iack, ierr, ddat, dack, derr};
  endfunction

  task automatic model_edge();
    logic ri, rd, mcyc;
    ri = iwbs_cyc & iwbs_stb;
    rd = dwbs_cyc & dwbs_stb;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k] = 0; last[k] = 1; cnt[k] = 0;
      end else if (own[k] == 0) begin
        if (ri && rd)  own[k] = (rr_cfg[k] != 0 && last[k] == 2) ? 1 : 2;
        else if (rd)   own[k] = 2;
        else if (ri)   own[k] = 1;
        cnt[k] = 0;
      end else begin
        mcyc = (own[k] == 1) ? iwbs_cyc : dwbs_cyc;
        if (s_ack || s_err || model_tmo(k)) begin
          last[k] = own[k]; own[k] = 0;
        end else if (!mcyc) begin
          own[k] = 0;
        end else begin
          cnt[k]++;
        end
      end
    end
  endtask

  task automatic check_model();
    check("model_a", a_vec, model_out(0));
    check("model_b", b_vec, model_out(1));
  endtask

  task automatic drive(input logic icyc, input logic istb, input logic dcyc, input logic dstb,
                       input logic ack, input logic err, input logic [31:0] sdat);
    iwbs_cyc = icyc; iwbs_stb = istb; dwbs_cyc = dcyc; dwbs_stb = dstb;
    s_ack = ack; s_err = err; s_dat = sdat;
    #2;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
  endtask

  logic [7:0] seq;
  int         ngr;

  initial begin
    for (int k = 0; k < 2; k++) begin own[k] = 0; last[k] = 1; cnt[k] = 0; end
    #1;
    drive(0, 0, 0, 0, 0, 0, '0);
    check("reset_a_all_zero", a_vec, '0);
    check("reset_b_all_zero", b_vec, '0);
    tick();
    drive(1, 1, 1, 1, 1, 0, 32'hFFFF_FFFF);
    check("reset_holds_idle", a_cyc, 1'b0);
    tick();
    rst = 1'b0;

    // Single I read, acked on the second bus cycle
    drive(1, 1, 0, 0, 0, 0, '0);
    check("t1_no_comb_forward", a_cyc, 1'b0);
    tick();
    drive(1, 1, 0, 0, 0, 0, '0);
    check("t1_cyc_rises", a_cyc, 1'b1);
    check("t1_addr", a_addr, I_ADDR);
    tick();
    drive(1, 1, 0, 0, 1, 0, 32'h0000_0013);
    check("t1_iack", a_iack, 1'b1);
    check("t1_idat", a_idat, 32'h0000_0013);
    check("t1_dack_quiet", a_dack, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    check("t1_idle_after", a_cyc, 1'b0);
    tick();

    // Both masters request continuously, slave acks immediately
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 1, 1, 0, 32'hA0 + i);
      if (a_iack || a_dack) seq = {seq[6:0], a_dack};
      tick();
    end
    check("t2_rr_order_DIDI", seq[3:0], 4'b1010);

    // Fixed priority: D wins three times, then drops and I gets the bus
    seq = '0; ngr = 0;
    for (int p = 0; p < 8; p++) begin
      drive(1, 1, p < 6, p < 6, 1, 0, 32'hB0 + p);
      if (b_iack || b_dack) begin seq = {seq[6:0], b_dack}; ngr++; end
      tick();
    end
    check("t3_fixed_order_DDDI", seq[3:0], 4'b1110);
    check("t3_grant_count", ngr, 4);
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();

    // D write to a slave that never answers; I waits behind it
    drive(0, 0, 1, 1, 0, 0, '0);
    tick();
    for (int q = 1; q <= 4; q++) begin
      drive(1, 1, 1, 1, 0, 0, '0);
      check($sformatf("t4_derr_busy%0d", q), a_derr, q == 4);
      if (q == 4) check("t4_b_no_timer", b_derr, 1'b0);
      tick();
    end
    drive(1, 1, 1, 1, 0, 0, '0);
    check("t4_bus_released", a_cyc, 1'b0);
    tick();
    drive(1, 1, 0, 0, 1, 0, 32'h55);
    check("t4_i_granted", a_addr, I_ADDR);
    check("t4_i_ack", a_iack, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();

    // D transfer sets last grant, then I aborts and a late ack arrives
    drive(0, 0, 1, 1, 0, 0, '0);
    tick();
    drive(0, 0, 1, 1, 1, 0, 32'h77);
    tick();
    drive(1, 1, 0, 0, 0, 0, '0);
    tick();
    drive(1, 1, 0, 0, 0, 0, '0);
    check("t5_i_busy", a_cyc, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    check("t5_abort_drops_cyc", a_cyc, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();
    drive(1, 1, 1, 1, 1, 0, 32'h99);
    check("t5_late_ack_i", a_iack, 1'b0);
    check("t5_late_ack_d", a_dack, 1'b0);
    tick();
    drive(1, 1, 1, 1, 1, 0, 32'h42);
    check("t5_last_grant_kept", a_addr, I_ADDR);
    tick();
    drive(1, 1, 1, 1, 0, 0, '0);
    tick();
    drive(0, 0, 1, 1, 1, 0, 32'h24);
    check("t5_d_granted", a_dack, 1'b1);
    check("t5_d_data", a_ddat, 32'h24);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();

    // Asynchronous reset in the middle of a D transfer
    drive(0, 0, 1, 1, 0, 0, '0);
    tick();
    drive(0, 0, 1, 1, 0, 0, '0);
    check("t6_busy_before_rst", a_cyc, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_async_cyc", a_cyc, 1'b0);
    check("t6_async_stb", a_stb, 1'b0);
    check("t6_async_we", a_we, 1'b0);
    check("t6_async_cyc_b", b_cyc, 1'b0);
    check_model();
    tick();
    drive(1, 1, 1, 1, 0, 0, '0);
    tick();
    rst = 1'b0;
    drive(1, 1, 1, 1, 0, 0, '0);
    check("t6_idle_after_rst", a_cyc, 1'b0);
    tick();
    drive(1, 1, 1, 1, 1, 0, 32'h5A);
    check("t6_first_grant_d_a", a_dack, 1'b1);
    check("t6_first_grant_d_b", b_dack, 1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, '0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
